// File: rtl/mean_window_feeder.sv
// Window accumulator feeding a dividend/divisor pair to a downstream divider.
// Optional MEAN_FEED_STATS_EN adds win_count/sat_count.
module mean_window_feeder #(
  parameter int DATAWIDTH_IN  = 24,
  parameter int DATAWIDTH_OUT = 32,
  parameter int B_SHIFT       = 0
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [7:0]                      cfg_len,
  input  logic                            s_axis_tvalid,
  input  logic signed [DATAWIDTH_IN-1:0]  s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_a_tvalid,
  output logic [DATAWIDTH_OUT-1:0]        m_axis_a_tdata,
  output logic                            m_axis_b_tvalid,
  output logic [7:0]                      m_axis_b_tdata,
  output logic                            sat_flag
`ifdef MEAN_FEED_STATS_EN
  ,
  output logic [15:0]                     win_count,
  output logic [15:0]                     sat_count
`endif
);

  localparam int AW = DATAWIDTH_IN + 8;
  localparam int SW = (AW > DATAWIDTH_OUT) ? AW : DATAWIDTH_OUT;
  localparam int DW = 9 + B_SHIFT;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                     state;
  logic signed [AW-1:0]       acc;
  logic signed [AW-1:0]       acc_next;
  logic signed [AW-1:0]       sample_ext;
  logic [7:0]                 cnt;
  logic [7:0]                 cnt_next;
  logic [7:0]                 len_q;
  logic [7:0]                 len_eff;
  logic                       close;
  logic signed [SW-1:0]       acc_wide;
  logic [SW-DATAWIDTH_OUT:0]  acc_top;
  logic                       sat_a;
  logic [DATAWIDTH_OUT-1:0]   sum_sat;
  logic [DW-1:0]              div_wide;
  logic                       sat_b;
  logic [7:0]                 div_sat;
  logic                       pulse;

  always_comb begin
    sample_ext = AW'(s_axis_tdata);
    acc_next   = sample_ext;
    cnt_next   = 8'd1;
    len_eff    = cfg_len;
    // The window length is taken from cfg_len only on the opening sample.
    if (state == ACCUM) begin
      acc_next = acc + sample_ext;
      cnt_next = cnt + 8'd1;
      len_eff  = len_q;
    end

    close = s_axis_tvalid &&
            (s_axis_tlast || ((len_eff != 8'd0) && (cnt_next == len_eff)) || (cnt_next == 8'd255));

    // Sum fits the output iff all bits above the output sign bit match it.
    acc_wide = SW'(acc_next);
    acc_top  = acc_wide[SW-1:DATAWIDTH_OUT-1];
    sat_a    = !((&acc_top) || !(|acc_top));
    sum_sat  = acc_wide[DATAWIDTH_OUT-1:0];
    if (sat_a) begin
      sum_sat = acc_wide[SW-1] ? {1'b1, {(DATAWIDTH_OUT-1){1'b0}}}
                               : {1'b0, {(DATAWIDTH_OUT-1){1'b1}}};
    end

    div_wide = DW'(cnt_next) << B_SHIFT;
    sat_b    = |div_wide[DW-1:8];
    div_sat  = sat_b ? 8'hFF : div_wide[7:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      len_q          <= '0;
      pulse          <= 1'b0;
      m_axis_a_tdata <= '0;
      m_axis_b_tdata <= '0;
      sat_flag       <= 1'b0;
    end else begin
      pulse    <= close;
      sat_flag <= close && (sat_a || sat_b);
      if (close) begin
        m_axis_a_tdata <= sum_sat;
        m_axis_b_tdata <= div_sat;
      end
      if (s_axis_tvalid) begin
        if (state == IDLE) len_q <= cfg_len;
        if (close) begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          state <= ACCUM;
          acc   <= acc_next;
          cnt   <= cnt_next;
        end
      end
    end
  end

  assign m_axis_a_tvalid = pulse;
  assign m_axis_b_tvalid = pulse;

`ifdef MEAN_FEED_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      win_count <= '0;
      sat_count <= '0;
    end else if (pulse) begin
      win_count <= win_count + 16'd1;
      if (sat_flag && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mean_window_feeder.sv
// Directed bench: one instance with B_SHIFT=0, one with B_SHIFT=7, sharing stimulus.
module tb_mean_window_feeder;

  logic               aclk;
  logic               areset;
  logic [7:0]         cfg_len;
  logic               s_vld;
  logic signed [23:0] s_dat;
  logic               s_last;

  logic        a_vld0, b_vld0, sat0;
  logic [31:0] a_dat0;
  logic [7:0]  b_dat0;
  logic        a_vld7, b_vld7, sat7;
  logic [31:0] a_dat7;
  logic [7:0]  b_dat7;
`ifdef MEAN_FEED_STATS_EN
  logic [15:0] win_cnt0, sat_cnt0, win_cnt7, sat_cnt7;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_sum;

  mean_window_feeder #(.DATAWIDTH_IN(24), .DATAWIDTH_OUT(32), .B_SHIFT(0)) dut (
    .aclk(aclk), .areset(areset), .cfg_len(cfg_len),
    .s_axis_tvalid(s_vld), .s_axis_tdata(s_dat), .s_axis_tlast(s_last),
    .m_axis_a_tvalid(a_vld0), .m_axis_a_tdata(a_dat0),
    .m_axis_b_tvalid(b_vld0), .m_axis_b_tdata(b_dat0), .sat_flag(sat0)
`ifdef MEAN_FEED_STATS_EN
    , .win_count(win_cnt0), .sat_count(sat_cnt0)
`endif
  );

  mean_window_feeder #(.DATAWIDTH_IN(24), .DATAWIDTH_OUT(32), .B_SHIFT(7)) dut7 (
    .aclk(aclk), .areset(areset), .cfg_len(cfg_len),
    .s_axis_tvalid(s_vld), .s_axis_tdata(s_dat), .s_axis_tlast(s_last),
    .m_axis_a_tvalid(a_vld7), .m_axis_a_tdata(a_dat7),
    .m_axis_b_tvalid(b_vld7), .m_axis_b_tdata(b_dat7), .sat_flag(sat7)
`ifdef MEAN_FEED_STATS_EN
    , .win_count(win_cnt7), .sat_count(sat_cnt7)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one input beat, let the edge take it, then settle 1 time unit.
  task automatic cyc(input logic v, input logic signed [23:0] d, input logic l);
    s_vld  = v;
    s_dat  = d;
    s_last = l;
    @(posedge aclk);
    #1;
    s_vld  = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic chk_pulse(input string tag, input logic [31:0] a, input logic [7:0] b, input logic s);
    chk({tag, "_avld"}, {31'd0, a_vld0}, 32'd1);
    chk({tag, "_bvld"}, {31'd0, b_vld0}, 32'd1);
    chk({tag, "_adat"}, a_dat0, a);
    chk({tag, "_bdat"}, {24'd0, b_dat0}, {24'd0, b});
    chk({tag, "_sat"},  {31'd0, sat0}, {31'd0, s});
  endtask

  initial begin
    areset  = 1'b1;
    cfg_len = 8'd0;
    s_vld   = 1'b0;
    s_dat   = '0;
    s_last  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_avld", {31'd0, a_vld0}, 32'd0);
    chk("rst_bvld", {31'd0, b_vld0}, 32'd0);
    chk("rst_adat", a_dat0, 32'd0);
    chk("rst_bdat", {24'd0, b_dat0}, 32'd0);
    chk("rst_sat",  {31'd0, sat0}, 32'd0);
    areset = 1'b0;

    // Fixed length 4, consecutive samples
    cfg_len = 8'd4;
    cyc(1'b1, 24'sd10, 1'b0);
    chk("len4_s1", {31'd0, a_vld0}, 32'd0);
    cyc(1'b1, 24'sd20, 1'b0);
    cyc(1'b1, 24'sd30, 1'b0);
    chk("len4_s3", {31'd0, a_vld0}, 32'd0);
    cyc(1'b1, 24'sd40, 1'b0);
    chk_pulse("len4", 32'd100, 8'd4, 1'b0);
    cyc(1'b0, 24'sd0, 1'b0);
    chk("len4_vld_drop", {31'd0, a_vld0}, 32'd0);
    chk("len4_hold", a_dat0, 32'd100);

    // tlast-closed window with a valid-low gap inside
    cfg_len = 8'd0;
    cyc(1'b1, -24'sd5, 1'b0);
    cyc(1'b1, -24'sd7, 1'b0);
    cyc(1'b0, 24'sd0, 1'b0);
    chk("tlast_gap", {31'd0, a_vld0}, 32'd0);
    cyc(1'b1, 24'sd3, 1'b1);
    chk_pulse("tlast", 32'hFFFF_FFF7, 8'd3, 1'b0);

    // Back-to-back windows of 2
    cfg_len = 8'd2;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 24'(i), 1'b0);
      if (i % 2 == 0) chk_pulse($sformatf("b2b_%0d", i), 32'(2 * i - 1), 8'd2, 1'b0);
      else            chk($sformatf("b2b_idle_%0d", i), {31'd0, a_vld0}, 32'd0);
    end
    cyc(1'b0, 24'sd0, 1'b0);

    // Forced close at 255 samples of the positive maximum
    cfg_len = 8'd0;
    repeat (254) cyc(1'b1, 24'sh7FFFFF, 1'b0);
    chk("cnt255_pre", {31'd0, a_vld0}, 32'd0);
    cyc(1'b1, 24'sh7FFFFF, 1'b0);
    exp_sum = 32'd8388607 * 32'd255;
    chk_pulse("cnt255", exp_sum, 8'd255, 1'b0);
    chk("cnt255_sh7_bdat", {24'd0, b_dat7}, 32'd255);
    chk("cnt255_sh7_sat",  {31'd0, sat7}, 32'd1);
    cyc(1'b0, 24'sd0, 1'b0);

    // Divisor shift and divisor saturation on the B_SHIFT=7 instance
    cfg_len = 8'd1;
    cyc(1'b1, 24'sd8, 1'b0);
    chk("sh7_l1_vld",  {31'd0, a_vld7}, 32'd1);
    chk("sh7_l1_bvld", {31'd0, b_vld7}, 32'd1);
    chk("sh7_l1_adat", a_dat7, 32'd8);
    chk("sh7_l1_bdat", {24'd0, b_dat7}, 32'd128);
    chk("sh7_l1_sat",  {31'd0, sat7}, 32'd0);
    chk("sh0_l1_bdat", {24'd0, b_dat0}, 32'd1);
    cfg_len = 8'd2;
    cyc(1'b1, 24'sd8, 1'b0);
    chk("sh7_l2_mid", {31'd0, a_vld7}, 32'd0);
    cyc(1'b1, 24'sd8, 1'b0);
    chk("sh7_l2_vld",  {31'd0, a_vld7}, 32'd1);
    chk("sh7_l2_adat", a_dat7, 32'd16);
    chk("sh7_l2_bdat", {24'd0, b_dat7}, 32'd255);
    chk("sh7_l2_sat",  {31'd0, sat7}, 32'd1);
    chk("sh0_l2_sat",  {31'd0, sat0}, 32'd0);
    cyc(1'b0, 24'sd0, 1'b0);
    chk("sh7_sat_drop", {31'd0, sat7}, 32'd0);

    // Reset mid-window discards the partial sum
    cfg_len = 8'd4;
    repeat (3) cyc(1'b1, 24'sd1, 1'b0);
    chk("mid_pre", {31'd0, a_vld0}, 32'd0);
    areset = 1'b1;
    cyc(1'b0, 24'sd0, 1'b0);
    cyc(1'b0, 24'sd0, 1'b0);
    chk("mid_rst_vld",  {31'd0, a_vld0}, 32'd0);
    chk("mid_rst_adat", a_dat0, 32'd0);
    chk("mid_rst_bdat", {24'd0, b_dat0}, 32'd0);
    areset = 1'b0;
    cyc(1'b0, 24'sd0, 1'b0);
    chk("mid_post_idle", {31'd0, a_vld0}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 24'sd1, 1'b0);
      chk($sformatf("mid_new_%0d", i), {31'd0, a_vld0}, 32'd0);
    end
    cyc(1'b1, 24'sd1, 1'b0);
    chk_pulse("mid_new", 32'd4, 8'd4, 1'b0);
    cyc(1'b0, 24'sd0, 1'b0);
    chk("mid_end", {31'd0, a_vld0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
